// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: active-low glyph patterns {g,f,e,d,c,b,a},
// the blink phase type and a small power-of-ten helper.
package seg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    PHASE_OFF = 1'b0,
    PHASE_ON  = 1'b1
  } blink_phase_e;

  // Only ever called with elaboration-time exponents.
  function automatic int unsigned pow10(input int e);
    int unsigned p;
    p = 1;
    for (int i = 0; i < e; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// BCD digit to active-low 7-segment pattern; blank wins over dash, dash over digit.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0]       bcd,
  input  logic             dash,
  input  logic             blank,
  output logic [SEG_W-1:0] seg
);

  // NOTE: every output of an always_comb gets a value before any branch, so no latch can be inferred.
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else if (dash) begin
      seg = SEG_DASH;
    end else begin
      case (bcd)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_display_mux.sv
// Two-player multiplexed common-anode 7-segment driver: per-digit dwell, frame-coherent
// score latching, leading-zero blanking, overflow dashes and per-player blink.
module score_display_mux
  import seg_pkg::*;
#(
  parameter int DIGITS_PER_PLAYER = 2,
  parameter int SCORE_W           = 7,
  parameter int DWELL             = 1,
  parameter int BLINK_FRAMES      = 64,
  parameter int LZB               = 1
) (
  input  logic                           segclk,
  input  logic                           clr,
  input  logic [SCORE_W-1:0]             p1,
  input  logic [SCORE_W-1:0]             p2,
  input  logic [1:0]                     blink_en,
  input  logic                           blank,
  output logic [SEG_W-1:0]               seg,
  output logic [2*DIGITS_PER_PLAYER-1:0] an
);

  localparam int D          = DIGITS_PER_PLAYER;
  localparam int NUM_DIGITS = 2 * D;
  localparam int IDX_W      = $clog2(NUM_DIGITS);
  localparam int DW_W       = $clog2(DWELL + 1);
  localparam int FR_W       = $clog2(BLINK_FRAMES + 1);
  localparam logic [NUM_DIGITS-1:0] AN_LEFT = NUM_DIGITS'(1) << (NUM_DIGITS - 1);

  logic [IDX_W-1:0]   idx;
  logic [DW_W-1:0]    dwell_cnt;
  logic [FR_W-1:0]    frame_cnt;
  blink_phase_e       phase;
  logic               fresh;
  logic [SCORE_W-1:0] p1_sh, p2_sh;

  logic               slot_end, frame_end;
  logic [SCORE_W-1:0] p1_val, p2_val;
  logic [D-1:0][3:0]  p1_bcd, p2_bcd;
  logic [D-1:0]       p1_lz, p2_lz;
  logic               p1_ovf, p2_ovf;
  logic               sel_p2;
  logic [3:0]         cur_bcd;
  logic               cur_lz, cur_ovf, blink_off, dark;
  logic [SEG_W-1:0]   seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  assign slot_end  = (dwell_cnt == DW_W'(DWELL - 1));
  assign frame_end = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));

  // On the first cycle after reset the shadows are loaded and displayed at the same edge.
  assign p1_val = fresh ? p1 : p1_sh;
  assign p2_val = fresh ? p2 : p2_sh;

  assign p1_ovf = 32'(p1_val) > (pow10(D) - 1);
  assign p2_ovf = 32'(p2_val) > (pow10(D) - 1);

  // Arrays are indexed by decimal exponent: [0] is the units digit.
  always_comb begin
    p1_bcd = '0;
    p2_bcd = '0;
    p1_lz  = '0;
    p2_lz  = '0;
    for (int k = 0; k < D; k++) begin
      p1_bcd[k] = 4'((32'(p1_val) / pow10(k)) % 10);
      p2_bcd[k] = 4'((32'(p2_val) / pow10(k)) % 10);
      p1_lz[k]  = (k != 0) && (32'(p1_val) < pow10(k));
      p2_lz[k]  = (k != 0) && (32'(p2_val) < pow10(k));
    end
  end

  always_comb begin
    sel_p2  = int'(idx) >= D;
    cur_bcd = '0;
    cur_lz  = 1'b0;
    for (int k = 0; k < D; k++) begin
      if (int'(idx) == D - 1 - k) begin
        cur_bcd = p1_bcd[k];
        cur_lz  = p1_lz[k];
      end
      if (int'(idx) == 2 * D - 1 - k) begin
        cur_bcd = p2_bcd[k];
        cur_lz  = p2_lz[k];
      end
    end
    cur_ovf   = sel_p2 ? p2_ovf : p1_ovf;
    blink_off = (phase == PHASE_OFF) && (sel_p2 ? blink_en[1] : blink_en[0]);
    dark      = blank || blink_off || (!cur_ovf && (LZB != 0) && cur_lz);
    an_next   = dark ? '1 : ~(AN_LEFT >> idx);
  end

  seg_decoder u_dec (
    .bcd   (cur_bcd),
    .dash  (cur_ovf),
    .blank (dark),
    .seg   (seg_next)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge segclk) begin
    if (clr) begin
      idx       <= '0;
      dwell_cnt <= '0;
      frame_cnt <= '0;
      phase     <= PHASE_ON;
      fresh     <= 1'b1;
      p1_sh     <= '0;
      p2_sh     <= '0;
      seg       <= SEG_BLANK;
      an        <= '1;
    end else begin
      fresh <= 1'b0;
      seg   <= seg_next;
      an    <= an_next;

      if (fresh || frame_end) begin
        p1_sh <= p1;
        p2_sh <= p2;
      end

      if (slot_end) begin
        dwell_cnt <= '0;
        idx       <= frame_end ? '0 : idx + 1'b1;
      end else begin
        dwell_cnt <= dwell_cnt + 1'b1;
      end

      if (frame_end) begin
        if (frame_cnt == FR_W'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          phase     <= (phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_score_display_mux.sv
// Directed bench: a frame-per-row vector table for the DWELL=1 instances plus a
// hand-written DWELL=3 sequence with a mid-frame clear.
module tb_score_display_mux;

  logic       segclk = 1'b0;
  logic       clr    = 1'b1;
  logic [6:0] p1     = '0;
  logic [6:0] p2     = '0;
  logic [1:0] blink_en = '0;
  logic       blank  = 1'b0;

  logic [6:0] seg_m, seg_z, seg_w;
  logic [3:0] an_m, an_z, an_w;

  int checks = 0;
  int errors = 0;

  always #5 segclk = ~segclk;

  score_display_mux #(.DIGITS_PER_PLAYER(2), .SCORE_W(7), .DWELL(1), .BLINK_FRAMES(2), .LZB(1)) dut (
    .segclk(segclk), .clr(clr), .p1(p1), .p2(p2), .blink_en(blink_en), .blank(blank),
    .seg(seg_m), .an(an_m));

  score_display_mux #(.DIGITS_PER_PLAYER(2), .SCORE_W(7), .DWELL(1), .BLINK_FRAMES(2), .LZB(0)) dut_nz (
    .segclk(segclk), .clr(clr), .p1(p1), .p2(p2), .blink_en(blink_en), .blank(blank),
    .seg(seg_z), .an(an_z));

  score_display_mux #(.DIGITS_PER_PLAYER(2), .SCORE_W(7), .DWELL(3), .BLINK_FRAMES(2), .LZB(1)) dut_dw (
    .segclk(segclk), .clr(clr), .p1(p1), .p2(p2), .blink_en(blink_en), .blank(blank),
    .seg(seg_w), .an(an_w));

  // One row = one scan frame; an/seg hold slots 0..3 packed MSB-first.
  typedef struct {
    logic [6:0]  p1;
    logic [6:0]  p2;
    logic [1:0]  be;
    logic        blank;
    logic [15:0] an;
    logic [27:0] seg;
    bit          chk_nz;
    logic [15:0] nz_an;
    logic [27:0] nz_seg;
  } vec_t;

  localparam int NROWS = 11;
  vec_t tbl [NROWS];

  logic [15:0] dw_an  = 16'b0111_1011_1101_1110;
  logic [27:0] dw_seg = {7'b1111001, 7'b1111000, 7'b1111001, 7'b0100100};

  function automatic vec_t mk(input int a, input int b, input logic [1:0] be, input logic bl,
                              input logic [15:0] an, input logic [27:0] sg,
                              input bit nz = 1'b0, input logic [15:0] nan = '0,
                              input logic [27:0] nsg = '0);
    vec_t v;
    v.p1 = 7'(a); v.p2 = 7'(b); v.be = be; v.blank = bl;
    v.an = an; v.seg = sg; v.chk_nz = nz; v.nz_an = nan; v.nz_seg = nsg;
    return v;
  endfunction

  task automatic tick();
    @(posedge segclk);
    #1;
  endtask

  task automatic check(input string name, input logic [3:0] an_act, input logic [6:0] seg_act,
                       input logic [3:0] an_exp, input logic [6:0] seg_exp);
    checks++;
    if ({an_act, seg_act} !== {an_exp, seg_exp}) begin
      errors++;
      $display("FAIL %s: got an=%b seg=%b, expected an=%b seg=%b",
               name, an_act, seg_act, an_exp, seg_exp);
    end
  endtask

  initial begin
    logic [3:0] ea;
    logic [6:0] es;
    bit         lit;

    // Frame phases with BLINK_FRAMES=2: frames 0,1 ON; 2,3 OFF; 4,5 ON; 6,7 OFF; 8,9 ON; 10 OFF.
    tbl[0]  = mk(5, 0, 2'b00, 1'b0, 16'b1111_1011_1111_1110,
                 {7'b1111111, 7'b0010010, 7'b1111111, 7'b1000000},
                 1'b1, 16'b0111_1011_1101_1110,
                 {7'b1000000, 7'b0010010, 7'b1000000, 7'b1000000});
    tbl[1]  = mk(7, 12, 2'b00, 1'b0, 16'b1111_1011_1101_1110,
                 {7'b1111111, 7'b1111000, 7'b1111001, 7'b0100100});
    // p2 moves to 34 while index 2 is lit; index 3 of this frame must still show 2.
    tbl[2]  = mk(7, 12, 2'b00, 1'b0, 16'b1111_1011_1101_1110,
                 {7'b1111111, 7'b1111000, 7'b1111001, 7'b0100100});
    tbl[3]  = mk(7, 34, 2'b01, 1'b0, 16'b1111_1111_1101_1110,
                 {7'b1111111, 7'b1111111, 7'b0110000, 7'b0011001});
    tbl[4]  = mk(42, 42, 2'b01, 1'b0, 16'b0111_1011_1101_1110,
                 {7'b0011001, 7'b0100100, 7'b0011001, 7'b0100100});
    tbl[5]  = mk(42, 42, 2'b10, 1'b0, 16'b0111_1011_1101_1110,
                 {7'b0011001, 7'b0100100, 7'b0011001, 7'b0100100});
    tbl[6]  = mk(42, 42, 2'b10, 1'b0, 16'b0111_1011_1111_1111,
                 {7'b0011001, 7'b0100100, 7'b1111111, 7'b1111111});
    tbl[7]  = mk(0, 99, 2'b00, 1'b1, 16'b1111_1111_1111_1111,
                 {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111});
    tbl[8]  = mk(0, 99, 2'b00, 1'b0, 16'b1111_1011_1101_1110,
                 {7'b1111111, 7'b1000000, 7'b0010000, 7'b0010000});
    tbl[9]  = mk(100, 3, 2'b00, 1'b0, 16'b0111_1011_1111_1110,
                 {7'b0111111, 7'b0111111, 7'b1111111, 7'b0110000},
                 1'b1, 16'b0111_1011_1101_1110,
                 {7'b0111111, 7'b0111111, 7'b1000000, 7'b0110000});
    tbl[10] = mk(127, 10, 2'b00, 1'b0, 16'b0111_1011_1101_1110,
                 {7'b0111111, 7'b0111111, 7'b1111001, 7'b1000000});

    // Reset held for three edges with a nonzero score present.
    clr = 1'b1; p1 = tbl[0].p1; p2 = tbl[0].p2; blink_en = tbl[0].be; blank = tbl[0].blank;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset%0d", i), an_m, seg_m, 4'b1111, 7'b1111111);
    end
    check("reset dwell3", an_w, seg_w, 4'b1111, 7'b1111111);
    clr = 1'b0;

    // Scores for frame r+1 are presented before the last edge of frame r, where they latch.
    for (int r = 0; r < NROWS; r++) begin
      blink_en = tbl[r].be;
      blank    = tbl[r].blank;
      for (int s = 0; s < 4; s++) begin
        if (s == 3 && r + 1 < NROWS) begin
          p1 = tbl[r + 1].p1;
          p2 = tbl[r + 1].p2;
        end
        tick();
        check($sformatf("row%0d slot%0d", r, s), an_m, seg_m,
              tbl[r].an[15 - 4 * s -: 4], tbl[r].seg[27 - 7 * s -: 7]);
        if (tbl[r].chk_nz)
          check($sformatf("nolzb row%0d slot%0d", r, s), an_z, seg_z,
                tbl[r].nz_an[15 - 4 * s -: 4], tbl[r].nz_seg[27 - 7 * s -: 7]);
      end
    end

    // DWELL=3: each slot held three cycles; clear lands on the first cycle of index 2.
    clr = 1'b1; p1 = 7'd17; p2 = 7'd12; blink_en = 2'b01; blank = 1'b0;
    tick();
    check("dw reset", an_w, seg_w, 4'b1111, 7'b1111111);
    clr = 1'b0;
    for (int c = 0; c < 19; c++) begin
      int s;
      s = (c / 3) % 4;
      tick();
      check($sformatf("dw pre c%0d", c), an_w, seg_w, dw_an[15 - 4 * s -: 4], dw_seg[27 - 7 * s -: 7]);
    end
    clr = 1'b1;
    tick();
    check("dw midframe clr", an_w, seg_w, 4'b1111, 7'b1111111);
    clr = 1'b0;
    // After restart frames 0,1 are ON and frame 2 is OFF, so p1 goes dark only in frame 2.
    for (int c = 0; c < 36; c++) begin
      int s;
      int f;
      s   = (c / 3) % 4;
      f   = c / 12;
      lit = !(f == 2 && s < 2);
      ea  = lit ? dw_an[15 - 4 * s -: 4] : 4'b1111;
      es  = lit ? dw_seg[27 - 7 * s -: 7] : 7'b1111111;
      tick();
      check($sformatf("dw post f%0d c%0d", f, c), an_w, seg_w, ea, es);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
